// File: rtl/decode_forward_unit.sv
// ID stage: latches the instruction, decodes fields, drives bank read addresses,
// tracks the last three issued destinations for forwarding and stalls on load-use.
module decode_forward_unit #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 5,
  parameter int unsigned IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] rb,
  output logic [1:0]    mux_sel_a,
  output logic [1:0]    mux_sel_b,
  output logic [DW-1:0] imm,
  output logic          imm_sel,
  output logic [AW-1:0] rw_out,
  output logic          wen_out,
  output logic          load_out,
  output logic          issue_valid,
  output logic          stall
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] SEL_BANK = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_DM   = 2'b10;
  localparam logic [1:0] SEL_WB   = 2'b11;

  typedef struct packed {
    logic [AW-1:0] rw;
    logic          wen;
    logic          load;
  } hist_t;

  // Older entries only feed forwarding, so the load flag is not kept.
  typedef struct packed {
    logic [AW-1:0] rw;
    logic          wen;
  } fwd_t;

  logic [IW-1:0] id_instr;
  logic          id_valid;
  hist_t         d1;
  fwd_t          d2;
  fwd_t          d3;

  logic [5:0]    opcode;
  logic [AW-1:0] dec_rw;
  logic          use_a;
  logic          use_b;
  logic          dec_wr;
  logic          dec_wen;
  logic          dec_load;
  logic          dec_imm_sel;
  logic          issue;
  logic [1:0]    sel_a_c;
  logic [1:0]    sel_b_c;

  assign opcode = id_instr[31:26];
  assign dec_rw = AW'(id_instr[25:21]);
  assign ra     = AW'(id_instr[20:16]);
  assign rb     = AW'(id_instr[15:11]);

  // Opcode decode; unknown opcodes behave as a NOP.
  always_comb begin
    use_a       = 1'b0;
    use_b       = 1'b0;
    dec_wr      = 1'b0;
    dec_load    = 1'b0;
    dec_imm_sel = 1'b0;
    case (opcode)
      OP_RTYPE: begin use_a = 1'b1; use_b = 1'b1; dec_wr = 1'b1; end
      OP_ADDI:  begin use_a = 1'b1; dec_wr = 1'b1; dec_imm_sel = 1'b1; end
      OP_LW:    begin use_a = 1'b1; dec_wr = 1'b1; dec_load = 1'b1; dec_imm_sel = 1'b1; end
      OP_BEQ:   begin use_a = 1'b1; use_b = 1'b1; end
      default:  ;
    endcase
  end

  // R0 is hardwired, so a write to it never becomes a forwarding source.
  assign dec_wen = dec_wr & (dec_rw != '0);

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [AW-1:0] r,
                                         input hist_t h1, input fwd_t h2, input fwd_t h3);
    if (use_r && h1.wen && (h1.rw == r)) return SEL_EX;
    if (use_r && h2.wen && (h2.rw == r)) return SEL_DM;
    if (use_r && h3.wen && (h3.rw == r)) return SEL_WB;
    return SEL_BANK;
  endfunction

  assign sel_a_c = fwd_sel(use_a, ra, d1, d2, d3);
  assign sel_b_c = fwd_sel(use_b, rb, d1, d2, d3);

  assign stall = id_valid & d1.wen & d1.load &
                 ((use_a & (ra == d1.rw)) | (use_b & (rb == d1.rw)));
  assign instr_ready = ~stall;
  assign issue       = id_valid & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr <= '0;
      id_valid <= 1'b0;
    end else if (instr_ready) begin
      id_instr <= instr;
      id_valid <= instr_valid;
    end
  end

  // History shift and issue registers; a stall or empty ID slot issues a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      mux_sel_a   <= SEL_BANK;
      mux_sel_b   <= SEL_BANK;
      imm         <= '0;
      imm_sel     <= 1'b0;
      rw_out      <= '0;
      wen_out     <= 1'b0;
      load_out    <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      d3 <= d2;
      d2 <= '{rw: d1.rw, wen: d1.wen};
      if (issue) begin
        d1          <= '{rw: dec_rw, wen: dec_wen, load: dec_load};
        mux_sel_a   <= sel_a_c;
        mux_sel_b   <= sel_b_c;
        imm         <= DW'(id_instr[15:0]);
        imm_sel     <= dec_imm_sel;
        rw_out      <= dec_rw;
        wen_out     <= dec_wen;
        load_out    <= dec_load;
        issue_valid <= 1'b1;
      end else begin
        d1          <= '0;
        mux_sel_a   <= SEL_BANK;
        mux_sel_b   <= SEL_BANK;
        imm         <= '0;
        imm_sel     <= 1'b0;
        rw_out      <= '0;
        wen_out     <= 1'b0;
        load_out    <= 1'b0;
        issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_forward_unit.sv
// Randomized and directed bench for decode_forward_unit against a cycle-level
// model built from the decode table, a 3-entry issue history and the hazard rule.
module tb_decode_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  ra, rb, rw_out;
  logic [1:0]  mux_sel_a, mux_sel_b;
  logic [15:0] imm;
  logic        imm_sel, wen_out, load_out, issue_valid, stall;

  decode_forward_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ra(ra), .rb(rb), .mux_sel_a(mux_sel_a),
    .mux_sel_b(mux_sel_b), .imm(imm), .imm_sel(imm_sel), .rw_out(rw_out),
    .wen_out(wen_out), .load_out(load_out), .issue_valid(issue_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: ID slot plus the last three issued {rw, wen, load}, index 0 newest.
  logic [31:0] m_instr;
  logic        m_idv;
  logic [4:0]  h_rw  [3];
  logic        h_wen [3];
  logic        h_ld  [3];
  logic [1:0]  e_sel_a, e_sel_b;
  logic [15:0] e_imm;
  logic        e_imm_sel, e_wen, e_ld, e_iv;
  logic [4:0]  e_rw;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_r(input int d, input int a, input int b);
    logic [31:0] w;
    w = '0;
    w[31:26] = 6'h00; w[25:21] = 5'(d); w[20:16] = 5'(a); w[15:11] = 5'(b);
    return w;
  endfunction

  function automatic logic [31:0] f_i(input logic [5:0] op, input int d, input int a,
                                      input logic [15:0] k);
    return {op, 5'(d), 5'(a), k};
  endfunction

  task automatic decode(input logic [31:0] w, output logic ua, output logic ub,
                        output logic wr, output logic ld, output logic isel);
    ua = 0; ub = 0; wr = 0; ld = 0; isel = 0;
    if (w[31:26] == 6'h00)      begin ua = 1; ub = 1; wr = 1; end
    else if (w[31:26] == 6'h08) begin ua = 1; wr = 1; isel = 1; end
    else if (w[31:26] == 6'h23) begin ua = 1; wr = 1; ld = 1; isel = 1; end
    else if (w[31:26] == 6'h04) begin ua = 1; ub = 1; end
  endtask

  function automatic logic [1:0] fwd(input logic u, input logic [4:0] r);
    for (int i = 0; i < 3; i++)
      if (u && h_wen[i] && h_rw[i] == r) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_instr = '0; m_idv = 0; last_stall = 0;
    for (int i = 0; i < 3; i++) begin h_rw[i] = 0; h_wen[i] = 0; h_ld[i] = 0; end
    e_sel_a = 0; e_sel_b = 0; e_imm = 0; e_imm_sel = 0; e_wen = 0; e_ld = 0; e_iv = 0; e_rw = 0;
  endtask

  task automatic check_regs();
    check("mux_sel_a", 32'(mux_sel_a), 32'(e_sel_a));
    check("mux_sel_b", 32'(mux_sel_b), 32'(e_sel_b));
    check("imm", 32'(imm), 32'(e_imm));
    check("imm_sel", 32'(imm_sel), 32'(e_imm_sel));
    check("rw_out", 32'(rw_out), 32'(e_rw));
    check("wen_out", 32'(wen_out), 32'(e_wen));
    check("load_out", 32'(load_out), 32'(e_ld));
    check("issue_valid", 32'(issue_valid), 32'(e_iv));
  endtask

  // Called just after a negedge: drive, check combinational outputs, clock, check issue.
  task automatic step(input logic [31:0] w, input logic v);
    logic ua, ub, wr, ld, isel, st, iss;
    logic [4:0] a, b, d;
    instr = w; instr_valid = v;
    #1;
    decode(m_instr, ua, ub, wr, ld, isel);
    a = m_instr[20:16]; b = m_instr[15:11]; d = m_instr[25:21];
    wr = wr && (d != 0);
    st = m_idv && h_wen[0] && h_ld[0] &&
         ((ua && a == h_rw[0]) || (ub && b == h_rw[0]));
    check("stall", 32'(stall), 32'(st));
    check("instr_ready", 32'(instr_ready), 32'(!st));
    check("ra", 32'(ra), 32'(a));
    check("rb", 32'(rb), 32'(b));
    iss = m_idv && !st;
    e_sel_a = iss ? fwd(ua, a) : 2'd0;
    e_sel_b = iss ? fwd(ub, b) : 2'd0;
    e_imm = iss ? m_instr[15:0] : 16'd0;
    e_imm_sel = iss && isel;
    e_rw = iss ? d : 5'd0;
    e_wen = iss && wr;
    e_ld = iss && ld;
    e_iv = iss;
    for (int i = 2; i > 0; i--) begin h_rw[i] = h_rw[i-1]; h_wen[i] = h_wen[i-1]; h_ld[i] = h_ld[i-1]; end
    h_rw[0] = iss ? d : 5'd0; h_wen[0] = iss && wr; h_ld[0] = iss && ld;
    if (!st) begin m_instr = w; m_idv = v; end
    last_stall = st;
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0);
  endtask

  logic [31:0] rw_word;
  logic        rv;
  logic [5:0]  ops [5];

  initial begin
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23; ops[3] = 6'h04; ops[4] = 6'h3F;
    rst = 1; instr = '0; instr_valid = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_ready", 32'(instr_ready), 32'd1);
    check_regs();
    rst = 0;

    // Back-to-back R-types
    step(f_r(3, 1, 2), 1); step(f_r(4, 3, 1), 1); step(f_r(5, 3, 3), 1);
    check("rr_sel_a_d1", 32'(mux_sel_a), 32'd1);
    check("rr_sel_b_d1", 32'(mux_sel_b), 32'd0);
    bubbles(1);
    check("rr_sel_a_d2", 32'(mux_sel_a), 32'd2);
    check("rr_sel_b_d2", 32'(mux_sel_b), 32'd2);
    bubbles(3);

    // Load-use
    step(f_i(6'h23, 6, 1, 16'h0004), 1); step(f_r(7, 6, 2), 1);
    step(32'h0, 0);
    check("lu_stall_seen", 32'(last_stall), 32'd1);
    check("lu_bubble_iv", 32'(issue_valid), 32'd0);
    check("lu_bubble_wen", 32'(wen_out), 32'd0);
    step(32'h0, 0);
    check("lu_stall_once", 32'(last_stall), 32'd0);
    check("lu_add_iv", 32'(issue_valid), 32'd1);
    check("lu_add_sel_a", 32'(mux_sel_a), 32'd2);
    bubbles(3);

    // Priority d1 over d2/d3, then d3 alone
    step(f_r(3, 1, 2), 1); step(f_r(3, 1, 2), 1); step(f_r(3, 1, 2), 1);
    step(f_r(9, 3, 0), 1); bubbles(1);
    check("prio_d1", 32'(mux_sel_a), 32'd1);
    bubbles(3);
    step(f_r(3, 1, 2), 1); bubbles(2); step(f_r(10, 3, 1), 1); bubbles(1);
    check("prio_d3", 32'(mux_sel_a), 32'd3);
    bubbles(3);

    // R0 and no-write ops
    step(f_r(0, 1, 2), 1); step(f_r(11, 0, 0), 1);
    check("r0_wen", 32'(wen_out), 32'd0);
    bubbles(1);
    check("r0_sel_a", 32'(mux_sel_a), 32'd0);
    check("r0_sel_b", 32'(mux_sel_b), 32'd0);
    bubbles(3);
    step({6'h04, 5'd0, 5'd1, 5'd2, 11'd0}, 1); step(f_r(12, 1, 1), 1); bubbles(1);
    check("beq_sel_a", 32'(mux_sel_a), 32'd0);
    bubbles(3);

    // ADDI immediate and unknown opcode
    step(f_i(6'h08, 8, 1, 16'h8001), 1); bubbles(1);
    check("addi_imm_sel", 32'(imm_sel), 32'd1);
    check("addi_imm", 32'(imm), 32'h8001);
    check("addi_wen", 32'(wen_out), 32'd1);
    check("addi_rw", 32'(rw_out), 32'd8);
    step(f_i(6'h3F, 9, 1, 16'h1234), 1); bubbles(1);
    check("nop_wen", 32'(wen_out), 32'd0);
    check("nop_iv", 32'(issue_valid), 32'd1);
    bubbles(3);

    // Reset while stalled
    step(f_i(6'h23, 6, 1, 16'h0000), 1); step(f_r(7, 6, 2), 1);
    instr = 32'h0; instr_valid = 0; #1;
    check("rst_pre_stall", 32'(stall), 32'd1);
    rst = 1; #1;
    model_reset();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check_regs();
    @(negedge clk); rst = 0;
    step(f_r(13, 6, 6), 1); bubbles(1);
    check("post_rst_iv", 32'(issue_valid), 32'd1);
    check("post_rst_sel_a", 32'(mux_sel_a), 32'd0);
    check("post_rst_sel_b", 32'(mux_sel_b), 32'd0);

    // Random traffic; a stalled source keeps presenting the same word
    rw_word = '0; rv = 0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        rw_word = $urandom;
        rw_word[31:26] = ops[$urandom_range(0, 4)];
        rw_word[25:21] = 5'($urandom_range(0, 7));
        rw_word[20:16] = 5'($urandom_range(0, 7));
        rw_word[15:11] = 5'($urandom_range(0, 7));
        rv = ($urandom_range(0, 99) < 85);
      end
      step(rw_word, rv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
